wb_csr_bank: RTL and testbench

Parametrised Wishbone slave exposing a bank of NREGS read/write control registers and NSTAT read-only status words to the CPU.
Successor to the fixed four-register generic slave, with these additions:
- configurable register count and read wait states
- byte-select writes and optional byte-lane swap
- per-register write strobes and per-status read strobes
- cycle abort handling
Sits on the CSR side of peripheral cores (e.g. correlator channels), between the WB interconnect and core control/status logic.

---
 rtl/wb_csr_bank.sv | 151 +++++++++++++++
 tb/tb_wb_csr_bank.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_csr_bank.sv
// Wishbone CSR slave: NREGS read/write control registers followed by NSTAT read-only
// status words, with byte-select writes, optional lane swap and programmable read wait states.
module wb_csr_bank #(
  parameter int          NREGS     = 8,
  parameter int          NSTAT     = 4,
  parameter int          READ_WAIT = 2,
  parameter int          BYTE_SWAP = 1,
  parameter logic [31:0] RESET_VAL = 32'h00000000
) (
  input  logic                                   sys_clk,
  input  logic                                   sys_rst,
  input  logic [31:0]                            wb_adr_i,
  input  logic [31:0]                            wb_dat_i,
  output logic [31:0]                            wb_dat_o,
  input  logic [3:0]                             wb_sel_i,
  input  logic                                   wb_cyc_i,
  input  logic                                   wb_stb_i,
  input  logic                                   wb_we_i,
  output logic                                   wb_ack_o,
  output logic [32*NREGS-1:0]                    ctrl_o,
  output logic [NREGS-1:0]                       wr_strobe_o,
  input  logic [32*((NSTAT > 0) ? NSTAT : 1)-1:0] stat_i,
  output logic [((NSTAT > 0) ? NSTAT : 1)-1:0]   rd_strobe_o
);

  localparam int         NS1       = (NSTAT > 0) ? NSTAT : 1;
  localparam logic [2:0] WAIT_INIT = (READ_WAIT > 0) ? 3'(READ_WAIT - 1) : 3'd0;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t             state_q;
  logic               ack_q;
  logic [31:0]        dat_q;
  logic [31:0]        hold_q;
  logic [2:0]         wait_q;
  logic [31:0]        ctrl_q [NREGS];
  logic [NREGS-1:0]   wr_strobe_q;
  logic [NS1-1:0]     rd_strobe_q;

  logic [7:0]         idx;
  logic               is_ctrl;
  logic               is_stat;
  logic [31:0]        dat_in;
  logic [3:0]         sel_in;
  logic [31:0]        rd_src;
  logic               unused_adr;

  assign unused_adr = ^{wb_adr_i[31:10], wb_adr_i[1:0]};

  function automatic logic [31:0] swap32(input logic [31:0] d);
    return (BYTE_SWAP != 0) ? {d[7:0], d[15:8], d[23:16], d[31:24]} : d;
  endfunction

  function automatic logic [3:0] swap4(input logic [3:0] s);
    return (BYTE_SWAP != 0) ? {s[0], s[1], s[2], s[3]} : s;
  endfunction

  always_comb begin
    idx     = wb_adr_i[9:2];
    is_ctrl = ({1'b0, idx} < 9'(NREGS));
    is_stat = !is_ctrl && ({1'b0, idx} < 9'(NREGS + NSTAT));
    dat_in  = swap32(wb_dat_i);
    sel_in  = swap4(wb_sel_i);
    // Unmapped indices fall through to zero
    rd_src  = 32'h0;
    for (int k = 0; k < NREGS; k++) begin
      if (is_ctrl && idx == 8'(k)) rd_src = ctrl_q[k];
    end
    for (int j = 0; j < NSTAT; j++) begin
      if (is_stat && idx == 8'(NREGS + j)) rd_src = stat_i[32*j +: 32];
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      ack_q       <= 1'b0;
      dat_q       <= 32'h0;
      hold_q      <= 32'h0;
      wait_q      <= 3'd0;
      wr_strobe_q <= '0;
      rd_strobe_q <= '0;
      for (int k = 0; k < NREGS; k++) ctrl_q[k] <= RESET_VAL;
    end else begin
      wr_strobe_q <= '0;
      rd_strobe_q <= '0;
      case (state_q)
        IDLE: begin
          if (wb_cyc_i && wb_stb_i) begin
            if (wb_we_i) begin
              // Strobe fires even with all byte enables clear
              for (int k = 0; k < NREGS; k++) begin
                if (is_ctrl && idx == 8'(k)) begin
                  wr_strobe_q[k] <= 1'b1;
                  for (int b = 0; b < 4; b++) begin
                    if (sel_in[b]) ctrl_q[k][8*b +: 8] <= dat_in[8*b +: 8];
                  end
                end
              end
              state_q <= ACK;
              ack_q   <= 1'b1;
              dat_q   <= 32'h0;
            end else begin
              hold_q <= rd_src;
              for (int j = 0; j < NSTAT; j++) begin
                if (is_stat && idx == 8'(NREGS + j)) rd_strobe_q[j] <= 1'b1;
              end
              if (READ_WAIT == 0) begin
                state_q <= ACK;
                ack_q   <= 1'b1;
                dat_q   <= swap32(rd_src);
              end else begin
                state_q <= WAIT;
                wait_q  <= WAIT_INIT;
              end
            end
          end
        end
        WAIT: begin
          if (!wb_cyc_i) begin
            state_q <= IDLE;
          end else if (wait_q == 3'd0) begin
            state_q <= ACK;
            ack_q   <= 1'b1;
            dat_q   <= swap32(hold_q);
          end else begin
            wait_q <= wait_q - 3'd1;
          end
        end
        ACK: begin
          state_q <= IDLE;
          ack_q   <= 1'b0;
          dat_q   <= 32'h0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wb_ack_o    = ack_q;
  assign wb_dat_o    = dat_q;
  assign wr_strobe_o = wr_strobe_q;
  assign rd_strobe_o = rd_strobe_q;

  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_ctrl
      assign ctrl_o[32*gi +: 32] = ctrl_q[gi];
    end
  endgenerate

endmodule

// File: tb/tb_wb_csr_bank.sv
// Bench for wb_csr_bank: two instances (straight and lane-swapped) share one bus and are
// checked every cycle against a cycle-indexed transaction model, plus directed literal checks.
module tb_wb_csr_bank;
  localparam int NREGS = 8;
  localparam int NSTAT = 4;
  localparam int RW    = 2;
  localparam int NCYC  = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0]        adr, dat_w;
  logic [3:0]         sel;
  logic               cyc, stb, we;
  logic [127:0]       stat;
  logic [1:0][31:0]   dat_o;
  logic [1:0]         ack_o;
  logic [1:0][255:0]  ctrl_o;
  logic [1:0][7:0]    wrs;
  logic [1:0][3:0]    rds;

  wb_csr_bank #(.NREGS(NREGS), .NSTAT(NSTAT), .READ_WAIT(RW), .BYTE_SWAP(0)) u_dut0 (
    .sys_clk(clk), .sys_rst(rst), .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_dat_o(dat_o[0]),
    .wb_sel_i(sel), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_ack_o(ack_o[0]),
    .ctrl_o(ctrl_o[0]), .wr_strobe_o(wrs[0]), .stat_i(stat), .rd_strobe_o(rds[0]));

  wb_csr_bank #(.NREGS(NREGS), .NSTAT(NSTAT), .READ_WAIT(RW), .BYTE_SWAP(1)) u_dut1 (
    .sys_clk(clk), .sys_rst(rst), .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_dat_o(dat_o[1]),
    .wb_sel_i(sel), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_ack_o(ack_o[1]),
    .ctrl_o(ctrl_o[1]), .wr_strobe_o(wrs[1]), .stat_i(stat), .rd_strobe_o(rds[1]));

  // Model state: register images per instance and per-cycle expected events
  bit [31:0] mctrl   [2][NREGS];
  bit        exp_ack [NCYC];
  bit [31:0] exp_dat [2][NCYC];
  bit [7:0]  exp_wr  [NCYC];
  bit [3:0]  exp_rd  [NCYC];
  bit        upd_v   [NCYC];
  int        upd_idx [NCYC];
  bit [31:0] upd_val [2][NCYC];

  int cyc_n  = 0;
  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  function automatic bit [31:0] sw32(input bit s, input bit [31:0] d);
    return s ? {d[7:0], d[15:8], d[23:16], d[31:24]} : d;
  endfunction

  function automatic bit [3:0] sw4(input bit s, input bit [3:0] v);
    return s ? {v[0], v[1], v[2], v[3]} : v;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic expect_write(input int t, input int idx, input bit [31:0] d, input bit [3:0] sl);
    bit [31:0] v, nd;
    bit [3:0]  ns;
    exp_ack[t+1] = 1'b1;
    for (int s = 0; s < 2; s++) exp_dat[s][t+1] = 32'h0;
    if (idx < NREGS) begin
      exp_wr[t+1][idx] = 1'b1;
      upd_v[t+1]       = 1'b1;
      upd_idx[t+1]     = idx;
      for (int s = 0; s < 2; s++) begin
        nd = sw32(s[0], d);
        ns = sw4(s[0], sl);
        v  = mctrl[s][idx];
        for (int b = 0; b < 4; b++) if (ns[b]) v[8*b +: 8] = nd[8*b +: 8];
        upd_val[s][t+1] = v;
      end
    end
  endtask

  task automatic expect_read(input int t, input int idx, input bit with_ack);
    bit [31:0] val [2];
    for (int s = 0; s < 2; s++) begin
      if (idx < NREGS)              val[s] = sw32(s[0], mctrl[s][idx]);
      else if (idx < NREGS + NSTAT) val[s] = sw32(s[0], stat[32*(idx-NREGS) +: 32]);
      else                          val[s] = 32'h0;
    end
    if (idx >= NREGS && idx < NREGS + NSTAT) exp_rd[t+1][idx-NREGS] = 1'b1;
    if (with_ack) begin
      exp_ack[t+1+RW] = 1'b1;
      for (int s = 0; s < 2; s++) exp_dat[s][t+1+RW] = val[s];
    end
  endtask

  always @(negedge clk) begin : compare
    int c;
    logic [255:0] ev;
    if (chk_en && !rst) begin
      c = cyc_n;
      if (upd_v[c]) for (int s = 0; s < 2; s++) mctrl[s][upd_idx[c]] = upd_val[s][c];
      for (int s = 0; s < 2; s++) begin
        for (int k = 0; k < NREGS; k++) ev[32*k +: 32] = mctrl[s][k];
        check($sformatf("ack[%0d]", s), 256'(ack_o[s]), 256'(exp_ack[c]));
        check($sformatf("dat[%0d]", s), 256'(dat_o[s]), 256'(exp_ack[c] ? exp_dat[s][c] : 32'h0));
        check($sformatf("ctrl[%0d]", s), ctrl_o[s], ev);
        check($sformatf("wr_strobe[%0d]", s), 256'(wrs[s]), 256'(exp_wr[c]));
        check($sformatf("rd_strobe[%0d]", s), 256'(rds[s]), 256'(exp_rd[c]));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit w, input int idx, input bit [31:0] d, input bit [3:0] sl);
    adr   = 32'(idx) << 2;
    we    = w;
    dat_w = d;
    sel   = sl;
    cyc   = 1'b1;
    stb   = 1'b1;
  endtask

  task automatic idle_bus;
    cyc = 1'b0;
    stb = 1'b0;
    we  = 1'b0;
  endtask

  task automatic wb_write(input int idx, input bit [31:0] d, input bit [3:0] sl);
    tick;
    drive(1'b1, idx, d, sl);
    expect_write(cyc_n, idx, d, sl);
    tick;
    idle_bus;
  endtask

  task automatic wb_read(input int idx);
    tick;
    drive(1'b0, idx, 32'h0, 4'h0);
    expect_read(cyc_n, idx, 1'b1);
    repeat (1 + RW) tick;
    idle_bus;
  endtask

  initial begin
    idle_bus;
    adr = 32'h0; dat_w = 32'h0; sel = 4'h0; stat = '0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    chk_en = 1'b1;

    // Full write through the lane swap
    tick;
    drive(1'b1, 3, 32'h11223344, 4'hF);
    expect_write(cyc_n, 3, 32'h11223344, 4'hF);
    tick;
    check("full_wr_ack", 256'(ack_o[1]), 256'(1'b1));
    check("full_wr_strobe", 256'(wrs[1]), 256'(8'b00001000));
    check("full_wr_swap_val", 256'(ctrl_o[1][127:96]), 256'(32'h44332211));
    check("full_wr_straight_val", 256'(ctrl_o[0][127:96]), 256'(32'h11223344));
    idle_bus;
    tick;
    check("full_wr_strobe_end", 256'(wrs[1]), 256'(8'h00));
    wb_read(3);

    // Partial write
    wb_write(0, 32'hAABBCCDD, 4'hF);
    wb_write(0, 32'h00001234, 4'b0011);
    check("partial_wr_straight", 256'(ctrl_o[0][31:0]), 256'(32'hAABB1234));
    check("partial_wr_swap", 256'(ctrl_o[1][31:0]), 256'(32'h3412BBAA));
    wb_write(4, 32'h99999999, 4'b0000);

    // Status read, sampled at accept
    stat[63:32] = 32'hCAFE0001;
    tick;
    drive(1'b0, 9, 32'h0, 4'h0);
    expect_read(cyc_n, 9, 1'b1);
    tick;
    check("stat_rd_strobe_t1", 256'(rds[0]), 256'(4'b0010));
    stat[63:32] = 32'h0;
    tick;
    check("stat_rd_strobe_t2", 256'(rds[0]), 256'(4'b0000));
    check("stat_no_early_ack", 256'(ack_o[0]), 256'(1'b0));
    tick;
    check("stat_ack_t3", 256'(ack_o[0]), 256'(1'b1));
    check("stat_dat_straight", 256'(dat_o[0]), 256'(32'hCAFE0001));
    check("stat_dat_swap", 256'(dat_o[1]), 256'(32'h0100FECA));
    idle_bus;

    // Abort during the wait phase
    stat[31:0] = 32'h12345678;
    tick;
    drive(1'b0, 8, 32'h0, 4'h0);
    expect_read(cyc_n, 8, 1'b0);
    tick;
    idle_bus;
    repeat (4) tick;
    wb_write(0, 32'h5A5A5A5A, 4'hF);
    check("post_abort_ack", 256'(ack_o[0]), 256'(1'b1));

    // Unmapped accesses
    wb_read(200);
    wb_write(200, 32'hFFFFFFFF, 4'hF);

    // Back-to-back writes with strobe held high
    tick;
    drive(1'b1, 5, 32'h01010101, 4'hF);
    expect_write(cyc_n, 5, 32'h01010101, 4'hF);
    tick;
    check("b2b_ack1", 256'(ack_o[0]), 256'(1'b1));
    drive(1'b1, 6, 32'h02020202, 4'hF);
    tick;
    check("b2b_gap", 256'(ack_o[0]), 256'(1'b0));
    expect_write(cyc_n, 6, 32'h02020202, 4'hF);
    tick;
    check("b2b_ack2", 256'(ack_o[0]), 256'(1'b1));
    idle_bus;

    // Asynchronous reset mid-read
    tick;
    drive(1'b0, 1, 32'h0, 4'h0);
    tick;
    #3 rst = 1'b1;
    idle_bus;
    for (int s = 0; s < 2; s++) for (int k = 0; k < NREGS; k++) mctrl[s][k] = 32'h0;
    #1;
    for (int s = 0; s < 2; s++) begin
      check($sformatf("rst_ack[%0d]", s), 256'(ack_o[s]), 256'(1'b0));
      check($sformatf("rst_dat[%0d]", s), 256'(dat_o[s]), 256'(32'h0));
      check($sformatf("rst_ctrl[%0d]", s), ctrl_o[s], 256'h0);
      check($sformatf("rst_strobes[%0d]", s), 256'({wrs[s], rds[s]}), 256'h0);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (4) tick;

    wb_write(2, 32'hDEADBEEF, 4'b1000);
    wb_read(2);
    repeat (3) tick;

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
